// File: rtl/hazard_pkg.sv
// Shared constants for the pipeline hazard controller: JALR decode fields,
// FSM state encoding and the hard-wired zero register index.
package hazard_pkg;

    localparam logic [6:0] OPCODE_JALR = 7'b1100111;
    localparam logic [2:0] FUNCT3_JALR = 3'b000;
    localparam int unsigned REG_ZERO   = 0;

    typedef enum logic {
        RUN       = 1'b0,
        DMEM_WAIT = 1'b1
    } hcu_state_t;

endpackage

// File: rtl/sat_counter.sv
// Free-running event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/hazard_control_unit.sv
// Stall/flush controller for hazards forwarding cannot cover: load-use, JALR
// base from a pending load, data-memory freeze and EX redirects.
module hazard_control_unit
    import hazard_pkg::*;
#(
    parameter int unsigned REGFILE_LEN    = 6,
    parameter int unsigned INSTR_WIDTH    = 32,
    parameter int unsigned OPCODE_WIDTH   = 7,
    parameter int unsigned FUNCT3_WIDTH   = 3,
    parameter int unsigned PERF_CNT_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [INSTR_WIDTH-1:0]    instr_IF_ID,
    input  logic [REGFILE_LEN-1:0]    rs1_IF_ID,
    input  logic [REGFILE_LEN-1:0]    rs2_IF_ID,
    input  logic                      uses_rs2_IF_ID,
    input  logic [REGFILE_LEN-1:0]    rd_ID_EX,
    input  logic                      mem_read_ID_EX,
    input  logic                      reg_write_ID_EX,
    input  logic [REGFILE_LEN-1:0]    rd_EX_MEM,
    input  logic                      mem_read_EX_MEM,
    input  logic                      dmem_busy,
    input  logic                      redirect_EX,
    output logic                      stall_PC,
    output logic                      stall_IF_ID,
    output logic                      flush_IF_ID,
    output logic                      stall_ID_EX,
    output logic                      bubble_ID_EX,
    output logic                      stall_EX_MEM,
    output logic                      bubble_MEM_WB,
    output logic                      freeze_active,
    output logic [PERF_CNT_WIDTH-1:0] stall_cycles,
    output logic [PERF_CNT_WIDTH-1:0] flush_events
);

    localparam int unsigned FUNCT3_LSB = 12;

    hcu_state_t state;
    logic       redirect_pend;

    logic [OPCODE_WIDTH-1:0] opcode;
    logic [FUNCT3_WIDTH-1:0] funct3;
    logic is_jalr, load_use, jalr_hazard, data_stall;
    logic freeze, redirect_apply;

    // Non-load ALU producers are forwarded, so reg_write and the rest of the
    // instruction word only matter to neighbouring units.
    logic unused_inputs;
    assign unused_inputs = ^{reg_write_ID_EX,
                             instr_IF_ID[INSTR_WIDTH-1:FUNCT3_LSB+FUNCT3_WIDTH],
                             instr_IF_ID[FUNCT3_LSB-1:OPCODE_WIDTH]};

    assign opcode  = instr_IF_ID[OPCODE_WIDTH-1:0];
    assign funct3  = instr_IF_ID[FUNCT3_LSB +: FUNCT3_WIDTH];
    assign is_jalr = (opcode == OPCODE_WIDTH'(OPCODE_JALR))
                  && (funct3 == FUNCT3_WIDTH'(FUNCT3_JALR));

    assign load_use = mem_read_ID_EX
                   && (rd_ID_EX != REGFILE_LEN'(REG_ZERO))
                   && ((rd_ID_EX == rs1_IF_ID)
                       || (uses_rs2_IF_ID && (rd_ID_EX == rs2_IF_ID)));

    assign jalr_hazard = is_jalr && (rs1_IF_ID != REGFILE_LEN'(REG_ZERO))
                      && ((mem_read_ID_EX  && (rd_ID_EX  == rs1_IF_ID))
                          || (mem_read_EX_MEM && (rd_EX_MEM == rs1_IF_ID)));

    assign data_stall     = load_use || jalr_hazard;
    assign freeze         = dmem_busy;
    assign redirect_apply = !freeze && (redirect_EX || redirect_pend);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= RUN;
            redirect_pend <= 1'b0;
        end else begin
            case (state)
                RUN:       if (dmem_busy)  state <= DMEM_WAIT;
                DMEM_WAIT: if (!dmem_busy) state <= RUN;
                default:   state <= RUN;
            endcase
            if (freeze) begin
                if (redirect_EX) redirect_pend <= 1'b1;
            end else begin
                redirect_pend <= 1'b0;
            end
        end
    end

    assign freeze_active = (state == DMEM_WAIT);

    // Mealy controls, forced low while reset is held so a busy memory cannot
    // leak stall requests through an asynchronous reset.
    always_comb begin
        stall_PC      = 1'b0;
        stall_IF_ID   = 1'b0;
        flush_IF_ID   = 1'b0;
        stall_ID_EX   = 1'b0;
        bubble_ID_EX  = 1'b0;
        stall_EX_MEM  = 1'b0;
        bubble_MEM_WB = 1'b0;
        if (!rst) begin
            if (freeze) begin
                stall_PC      = 1'b1;
                stall_IF_ID   = 1'b1;
                stall_ID_EX   = 1'b1;
                stall_EX_MEM  = 1'b1;
                bubble_MEM_WB = 1'b1;
            end else if (redirect_apply) begin
                flush_IF_ID  = 1'b1;
                bubble_ID_EX = 1'b1;
            end else if (data_stall) begin
                stall_PC     = 1'b1;
                stall_IF_ID  = 1'b1;
                bubble_ID_EX = 1'b1;
            end
        end
    end

    sat_counter #(.WIDTH(PERF_CNT_WIDTH)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_PC),
        .count (stall_cycles)
    );

    sat_counter #(.WIDTH(PERF_CNT_WIDTH)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (flush_IF_ID),
        .count (flush_events)
    );

endmodule

// File: doc/hazard_control_unit.md
Name: hazard_control_unit

Overview:
- Pipeline stall/flush controller in core/pipeline/hazard, working beside forwarding_unit.
- Covers the hazards that forwarding cannot resolve: load-use, JALR operand not yet available, data-memory busy freeze, and control redirects from EX.
- Drives enable/flush controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Holds a redirect that arrives during a freeze and keeps performance counters.

Parameters:
- REGFILE_LEN, 6, register index width
- INSTR_WIDTH, 32, instruction width
- OPCODE_WIDTH, 7, opcode field width
- FUNCT3_WIDTH, 3, funct3 field width
- PERF_CNT_WIDTH, 32, width of each performance counter

Ports:
- clk  input  1  core clock
- rst  input  1  asynchronous reset, active-high
- instr_IF_ID  input  INSTR_WIDTH  instruction in decode
- rs1_IF_ID  input  REGFILE_LEN  decode source 1
- rs2_IF_ID  input  REGFILE_LEN  decode source 2
- uses_rs2_IF_ID  input  1  decode instruction reads rs2
- rd_ID_EX  input  REGFILE_LEN  destination in EX
- mem_read_ID_EX  input  1  EX instruction is a load
- reg_write_ID_EX  input  1  EX instruction writes a register
- rd_EX_MEM  input  REGFILE_LEN  destination in MEM
- mem_read_EX_MEM  input  1  MEM instruction is a load
- dmem_busy  input  1  data memory has not completed this cycle
- redirect_EX  input  1  single-cycle pulse: taken branch/jump resolved in EX
- stall_PC  output  1  hold PC
- stall_IF_ID  output  1  hold IF/ID
- flush_IF_ID  output  1  IF/ID loads NOP
- stall_ID_EX  output  1  hold ID/EX
- bubble_ID_EX  output  1  ID/EX loads NOP
- stall_EX_MEM  output  1  hold EX/MEM
- bubble_MEM_WB  output  1  MEM/WB loads NOP
- freeze_active  output  1  FSM in DMEM_WAIT
- stall_cycles  output  PERF_CNT_WIDTH  cycles with stall_PC high
- flush_events  output  PERF_CNT_WIDTH  applied redirects

Behaviour:
- Reset: all outputs 0, state RUN, redirect_pend 0, counters 0.

Combinational detection (x0 destinations never hazard):
- is_jalr: opcode 1100111 and funct3 000.
- load_use: mem_read_ID_EX, rd_ID_EX != 0, and rd_ID_EX matches rs1_IF_ID, or matches rs2_IF_ID with uses_rs2_IF_ID.
- jalr_hazard: is_jalr and any of:
  - mem_read_ID_EX with rd_ID_EX == rs1_IF_ID != 0
  - mem_read_EX_MEM with rd_EX_MEM == rs1_IF_ID != 0
- ALU producers for JALR are forwarded by forwarding_unit and are never stalled here.
- data_stall = load_use or jalr_hazard.

FSM states: RUN, DMEM_WAIT.
- RUN to DMEM_WAIT: dmem_busy=1.
- DMEM_WAIT to RUN: first cycle with dmem_busy=0.
- Outputs are Mealy: the freeze applies in the same cycle dmem_busy first rises.

Priority per cycle: freeze > redirect > data_stall.
- Freeze (dmem_busy=1):
  - stall_PC, stall_IF_ID, stall_ID_EX, stall_EX_MEM and bubble_MEM_WB = 1.
  - All flushes 0.
  - A redirect_EX pulse sets redirect_pend.
- Redirect (redirect_EX or redirect_pend, no freeze):
  - flush_IF_ID = 1, bubble_ID_EX = 1, stalls 0.
  - redirect_pend clears next edge.
  - Any data_stall is discarded because the instruction in decode is squashed.
- data_stall only: stall_PC, stall_IF_ID and bubble_ID_EX = 1.
  - Detection re-evaluates each cycle, so JALR behind a load in EX takes 2 stall cycles; behind a load in MEM, 1.
- redirect_EX and redirect_pend both set: count as one event.
- Counters:
  - stall_cycles increments on every cycle with stall_PC=1.
  - flush_events increments on each applied redirect.
  - Both saturate at all-ones and do not wrap.
- rst mid-freeze: clears state, redirect_pend and outputs immediately (asynchronous).

Decomposition:
- Shared package, hazard_pkg: opcode constants (OPCODE_JALR=1100111, FUNCT3_JALR=000), FSM state encoding (RUN=0, DMEM_WAIT=1), register-zero constant.
- One natural sub-module: sat_counter (width parameter, inc, clk, rst), instantiated twice for the performance counters.

Test Plan:
- Load-use stall: load x5 in EX, decode add x6,x5,x7 → one cycle of stall_PC/stall_IF_ID/bubble_ID_EX=1, then all 0; stall_cycles=1.
- Store x0 guard: load x0 in EX, decode reading x0 → no stall.
- JALR behind load: load x1 in EX, decode jalr x0,0(x1) → stall 2 consecutive cycles (load in EX, then in MEM), then released.
- Freeze then redirect: dmem_busy high 3 cycles with redirect_EX pulsed in cycle 2 → freeze outputs for 3 cycles; cycle 4 has flush_IF_ID=bubble_ID_EX=1; flush_events=1.
- Redirect beats load-use: redirect_EX with load_use in the same cycle → flush only, no stall; stall_cycles unchanged.
- Saturation and reset: preload counter near max (PERF_CNT_WIDTH=4, 15 stall cycles + 3 more) → stall_cycles=15; assert rst during DMEM_WAIT → freeze_active=0 before next edge.
